// File: rtl/nav_pkg.sv
// Shared types and defaults for the ultrasonic ranger scheduler and its echo timer.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } sched_state_t;

    typedef enum logic [1:0] {
        TMR_IDLE,
        TMR_RISE,
        TMR_MEAS
    } tmr_state_t;

    localparam logic [1:0] SENSOR_SIDE_BACK  = 2'd0;
    localparam logic [1:0] SENSOR_SIDE_FRONT = 2'd1;
    localparam logic [1:0] SENSOR_FRONT      = 2'd2;
    localparam logic [1:0] SENSOR_BACK       = 2'd3;

    localparam int unsigned DEF_TRIG_CYCLES    = 500;
    localparam int unsigned DEF_RISE_TIMEOUT   = 75000;
    localparam int unsigned DEF_ECHO_TIMEOUT   = 1850000;
    localparam int unsigned DEF_CYC_PER_CM     = 5800;
    localparam int unsigned DEF_HOLDOFF_CYCLES = 20000;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // First enabled sensor at or after 'start', wrapping 3 -> 0.
    function automatic logic [1:0] pick_from(input logic [3:0] en, input logic [1:0] start);
        logic [1:0] sel;
        logic [1:0] cand;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && en[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/us_echo_timer.sv
// Synchronises the echo pins, waits for the selected echo to rise and converts
// its high time into whole centimetres, flagging missing or over-long echoes.
module us_echo_timer
    import nav_pkg::*;
#(
    parameter int unsigned RISE_TIMEOUT = DEF_RISE_TIMEOUT,
    parameter int unsigned ECHO_TIMEOUT = DEF_ECHO_TIMEOUT,
    parameter int unsigned CYC_PER_CM   = DEF_CYC_PER_CM
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [1:0] sel_i,
    input  logic [3:0] sig_i,
    output logic       rise_o,
    output logic       done_o,
    output logic       timeout_o,
    output logic [7:0] cm_o
);

    localparam int CNT_W = $clog2(max2(RISE_TIMEOUT, ECHO_TIMEOUT) + 1);
    localparam int SUB_W = $clog2(CYC_PER_CM + 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TIMEOUT - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYC_PER_CM - 1);

    logic [3:0] meta_q, sync_q, prev_q;
    logic [3:0] rise_v, fall_v;

    tmr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [7:0]       cm_q, cm_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
        assign rise_v[gi] = sync_q[gi] & ~prev_q[gi];
        assign fall_v[gi] = ~sync_q[gi] & prev_q[gi];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        rise_o    = 1'b0;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        cm_o      = cm_q;
        case (state_q)
            TMR_IDLE: begin
                if (start_i) begin
                    state_d = TMR_RISE;
                    cnt_d   = '0;
                end
            end
            TMR_RISE: begin
                // The edge cycle itself is the first counted echo cycle.
                if (rise_v[sel_i]) begin
                    rise_o  = 1'b1;
                    state_d = TMR_MEAS;
                    cnt_d   = CNT_W'(1);
                    sub_d   = SUB_W'(1);
                    cm_d    = '0;
                end else if (cnt_q == RISE_LAST) begin
                    done_o    = 1'b1;
                    timeout_o = 1'b1;
                    cm_o      = 8'hFF;
                    state_d   = TMR_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TMR_MEAS: begin
                if (fall_v[sel_i]) begin
                    done_o  = 1'b1;
                    state_d = TMR_IDLE;
                end else if (cnt_q == ECHO_LAST) begin
                    done_o    = 1'b1;
                    timeout_o = 1'b1;
                    cm_o      = 8'hFF;
                    state_d   = TMR_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != 8'hFF) begin
                            cm_d = cm_q + 8'd1;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            default: state_d = TMR_IDLE;
        endcase
    end

endmodule

// File: rtl/us_ping_scheduler.sv
// Round-robin scheduler for four single-pin ultrasonic rangers: one ping in
// flight at a time, with a quiet holdoff between measurements.
module us_ping_scheduler
    import nav_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned RISE_TIMEOUT   = DEF_RISE_TIMEOUT,
    parameter int unsigned ECHO_TIMEOUT   = DEF_ECHO_TIMEOUT,
    parameter int unsigned CYC_PER_CM     = DEF_CYC_PER_CM,
    parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  ENABLE,
    input  logic [3:0]  SIG_IN,
    output logic [3:0]  SIG_OUT,
    output logic [3:0]  SIG_OE,
    output logic [31:0] DISTANCE,
    output logic [3:0]  DIST_VALID,
    output logic [3:0]  TIMEOUT,
    output logic [1:0]  ACTIVE_IDX,
    output logic        BUSY
);

    localparam int CNT_W = $clog2(max2(TRIG_CYCLES, HOLDOFF_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dist_q, dist_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       tout_q, tout_d;

    logic       tmr_start;
    logic       tmr_rise, tmr_done, tmr_timeout;
    logic [7:0] tmr_cm;

    assign tmr_start = (state_q == TRIG) && (cnt_q == TRIG_LAST);

    us_echo_timer #(
        .RISE_TIMEOUT(RISE_TIMEOUT),
        .ECHO_TIMEOUT(ECHO_TIMEOUT),
        .CYC_PER_CM  (CYC_PER_CM)
    ) u_timer (
        .clk_i    (CLK),
        .rst_i    (RST),
        .start_i  (tmr_start),
        .sel_i    (idx_q),
        .sig_i    (SIG_IN),
        .rise_o   (tmr_rise),
        .done_o   (tmr_done),
        .timeout_o(tmr_timeout),
        .cm_o     (tmr_cm)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dist_q  <= '0;
            valid_q <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dist_q  <= dist_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        valid_d = '0;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                if (ENABLE != 4'b0000) begin
                    idx_d   = pick_from(ENABLE, idx_q);
                    cnt_d   = '0;
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RISE, MEASURE: begin
                // ENABLE is deliberately ignored here: a started ping always reports.
                if (tmr_done) begin
                    dist_d[{idx_q, 3'b000} +: 8] = tmr_cm;
                    tout_d[idx_q]  = tmr_timeout;
                    valid_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = HOLDOFF;
                end else if (tmr_rise) begin
                    state_d = MEASURE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (ENABLE == 4'b0000) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = pick_from(ENABLE, idx_q + 2'd1);
                        state_d = TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_pin
        assign SIG_OE[gi]  = (state_q == TRIG) && (idx_q == 2'(gi));
        assign SIG_OUT[gi] = (state_q == TRIG) && (idx_q == 2'(gi));
    end

    assign DISTANCE   = dist_q;
    assign DIST_VALID = valid_q;
    assign TIMEOUT    = tout_q;
    assign ACTIVE_IDX = idx_q;
    assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_us_ping_scheduler.sv
// Directed bench for us_ping_scheduler with shortened timing so each scenario
// completes in a few thousand cycles; an echo responder answers each trigger.
module tb_us_ping_scheduler;

    localparam int TRIG  = 5;
    localparam int RISE  = 200;
    localparam int ECHO  = 3000;
    localparam int CPC   = 10;
    localparam int HOLD  = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  enable = 4'b0000;
    logic [3:0]  sig_in = 4'b0000;
    logic [3:0]  sig_out, sig_oe, dist_valid, tout;
    logic [31:0] distance;
    logic [1:0]  active_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;

    int echo_w[4];
    int echo_dly = 2;
    bit resp_busy = 1'b0;
    int rise_cyc = 0;
    int fall_cyc = 0;

    int          oe_seq[$];
    int          oe_len[$];
    int          oe_start[$];
    int          oe_end[$];
    logic [3:0]  dv_mask[$];
    logic [31:0] dv_dist[$];
    logic [3:0]  dv_tout[$];
    logic [1:0]  dv_idx[$];
    int          dv_cyc[$];

    us_ping_scheduler #(
        .TRIG_CYCLES   (TRIG),
        .RISE_TIMEOUT  (RISE),
        .ECHO_TIMEOUT  (ECHO),
        .CYC_PER_CM    (CPC),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .ENABLE    (enable),
        .SIG_IN    (sig_in),
        .SIG_OUT   (sig_out),
        .SIG_OE    (sig_oe),
        .DISTANCE  (distance),
        .DIST_VALID(dist_valid),
        .TIMEOUT   (tout),
        .ACTIVE_IDX(active_idx),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction monitor: trigger pulses and result strobes, sampled on the falling edge.
    initial begin : monitor
        logic [3:0] prev;
        int run;
        int st;
        int sens;
        prev = 4'b0000;
        run  = 0;
        st   = 0;
        forever begin
            @(negedge clk);
            if ($countones(sig_oe) > 1) viol++;
            if (sig_oe != 4'b0000 && !busy) viol++;
            if (sig_oe != sig_out) viol++;
            if (sig_oe != 4'b0000) begin
                if (prev == 4'b0000) begin
                    st  = cyc;
                    run = 0;
                end
                run++;
            end else if (prev != 4'b0000) begin
                sens = 0;
                for (int b = 0; b < 4; b++) if (prev[b]) sens = b;
                oe_seq.push_back(sens);
                oe_len.push_back(run);
                oe_start.push_back(st);
                oe_end.push_back(cyc);
                $display("[%0d] trigger sensor=%0d len=%0d", cyc, sens, run);
            end
            if (dist_valid != 4'b0000) begin
                dv_mask.push_back(dist_valid);
                dv_dist.push_back(distance);
                dv_tout.push_back(tout);
                dv_idx.push_back(active_idx);
                dv_cyc.push_back(cyc);
                $display("[%0d] result valid=%b idx=%0d distance=%h timeout=%b",
                         cyc, dist_valid, active_idx, distance, tout);
            end
            prev = sig_oe;
        end
    end

    // Echo responder: answers the end of each trigger with a pulse of echo_w cycles.
    initial begin : responder
        logic [3:0] prev_oe;
        int sel;
        prev_oe = 4'b0000;
        forever begin
            @(negedge clk);
            sel = -1;
            for (int b = 0; b < 4; b++)
                if (prev_oe[b] && !sig_oe[b] && echo_w[b] > 0) sel = b;
            if (sel >= 0) begin
                resp_busy = 1'b1;
                repeat (echo_dly) @(negedge clk);
                sig_in[sel] = 1'b1;
                rise_cyc = cyc;
                repeat (echo_w[sel]) @(negedge clk);
                sig_in[sel] = 1'b0;
                fall_cyc = cyc;
                resp_busy = 1'b0;
            end
            prev_oe = sig_oe;
        end
    end

    task automatic clear_log();
        oe_seq.delete(); oe_len.delete(); oe_start.delete(); oe_end.delete();
        dv_mask.delete(); dv_dist.delete(); dv_tout.delete(); dv_idx.delete(); dv_cyc.delete();
    endtask

    task automatic wait_dv(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (dv_mask.size() >= n);
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = !busy && !resp_busy;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit busy_seen, oe_seen;
        rst = 1'b1;
        enable = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sig_oe !== 4'b0000) begin errors++; $display("FAIL reset_oe: got %b expected 0000", sig_oe); end
        checks++; if (sig_out !== 4'b0000) begin errors++; $display("FAIL reset_out: got %b expected 0000", sig_out); end
        checks++; if (distance !== 32'h0) begin errors++; $display("FAIL reset_dist: got %h expected 0", distance); end
        checks++; if (dist_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", dist_valid); end
        checks++; if (tout !== 4'b0000) begin errors++; $display("FAIL reset_timeout: got %b expected 0000", tout); end
        checks++; if (active_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", active_idx); end
        busy_seen = 1'b0;
        oe_seen   = 1'b0;
        repeat (300) begin
            @(negedge clk);
            busy_seen |= busy;
            oe_seen   |= (sig_oe != 4'b0000);
        end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_seen); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL idle_oe: got %b expected 0", oe_seen); end
        checks++; if (distance !== 32'h0) begin errors++; $display("FAIL idle_dist: got %h expected 0", distance); end
    endtask

    task automatic test_single();
        bit ok, ok2;
        clear_log();
        echo_w = '{0, 0, 100, 0};
        enable = 4'b0100;
        wait_dv(1, 1000, ok);
        enable = 4'b0000;
        wait_idle(2000, ok2);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_dv_seen: got %b expected 1", ok); end
        checks++; if (ok2 !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", ok2); end
        if (ok) begin
            checks++; if (oe_seq[0] !== 2) begin errors++; $display("FAIL single_sensor: got %0d expected 2", oe_seq[0]); end
            checks++; if (oe_len[0] !== TRIG) begin errors++; $display("FAIL single_trig_len: got %0d expected %0d", oe_len[0], TRIG); end
            checks++; if (dv_mask[0] !== 4'b0100) begin errors++; $display("FAIL single_valid: got %b expected 0100", dv_mask[0]); end
            checks++; if (dv_dist[0][23:16] !== 8'd10) begin errors++; $display("FAIL single_cm: got %0d expected 10", dv_dist[0][23:16]); end
            checks++; if (dv_tout[0][2] !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", dv_tout[0][2]); end
            checks++; if (dv_cyc[0] - fall_cyc !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", dv_cyc[0] - fall_cyc); end
            checks++; if (dv_mask.size() !== 1) begin errors++; $display("FAIL single_one_strobe: got %0d expected 1", dv_mask.size()); end
        end
        checks++; if (distance !== 32'h000A_0000) begin errors++; $display("FAIL single_dist_word: got %h expected 000a0000", distance); end
    endtask

    task automatic test_round_robin();
        bit ok, ok2;
        int exp_seq[4] = '{0, 1, 3, 0};
        pulse_reset();
        clear_log();
        echo_w = '{10, 10, 0, 10};
        enable = 4'b1011;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (oe_seq.size() >= 4);
        end
        enable = 4'b0000;
        wait_idle(2000, ok2);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_four_pings: got %b expected 1", ok); end
        checks++; if (ok2 !== 1'b1) begin errors++; $display("FAIL rr_idle: got %b expected 1", ok2); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (oe_seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, oe_seq[i], exp_seq[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (oe_start[i+1] - oe_end[i] < HOLD) begin errors++; $display("FAIL rr_gap[%0d]: got %0d expected >= %0d", i, oe_start[i+1] - oe_end[i], HOLD); end
            end
        end
        checks++; if (distance !== 32'h0100_0101) begin errors++; $display("FAIL rr_dist: got %h expected 01000101", distance); end
        checks++; if (tout !== 4'b0000) begin errors++; $display("FAIL rr_timeout: got %b expected 0000", tout); end
        checks++; if (dv_mask.size() !== 4) begin errors++; $display("FAIL rr_results: got %0d expected 4", dv_mask.size()); end
    endtask

    task automatic test_rise_timeout();
        bit ok, ok2, ok3;
        clear_log();
        echo_w = '{0, 0, 0, 0};
        enable = 4'b0001;
        wait_dv(1, 1000, ok);
        echo_w[0] = 200;
        wait_dv(2, 2000, ok2);
        enable = 4'b0000;
        wait_idle(2000, ok3);
        checks++; if (ok !== 1'b1 || ok2 !== 1'b1 || ok3 !== 1'b1) begin errors++; $display("FAIL rto_progress: got %b%b%b expected 111", ok, ok2, ok3); end
        if (ok2) begin
            checks++; if (dv_dist[0][7:0] !== 8'd255) begin errors++; $display("FAIL rto_byte: got %0d expected 255", dv_dist[0][7:0]); end
            checks++; if (dv_tout[0][0] !== 1'b1) begin errors++; $display("FAIL rto_flag: got %b expected 1", dv_tout[0][0]); end
            checks++; if (dv_cyc[0] - oe_end[0] !== RISE) begin errors++; $display("FAIL rto_wait: got %0d expected %0d", dv_cyc[0] - oe_end[0], RISE); end
            checks++; if (oe_seq[1] !== 0) begin errors++; $display("FAIL rto_repeat: got %0d expected 0", oe_seq[1]); end
            checks++; if (dv_dist[1][7:0] !== 8'd20) begin errors++; $display("FAIL rto_recover_byte: got %0d expected 20", dv_dist[1][7:0]); end
            checks++; if (dv_tout[1][0] !== 1'b0) begin errors++; $display("FAIL rto_recover_flag: got %b expected 0", dv_tout[1][0]); end
        end
    endtask

    task automatic test_long_echo();
        bit ok, ok2;
        clear_log();
        echo_w = '{4000, 0, 0, 0};
        enable = 4'b0001;
        wait_dv(1, 5000, ok);
        enable = 4'b0000;
        wait_idle(6000, ok2);
        checks++; if (ok !== 1'b1 || ok2 !== 1'b1) begin errors++; $display("FAIL eto_progress: got %b%b expected 11", ok, ok2); end
        if (ok) begin
            checks++; if (dv_dist[0][7:0] !== 8'd255) begin errors++; $display("FAIL eto_byte: got %0d expected 255", dv_dist[0][7:0]); end
            checks++; if (dv_tout[0][0] !== 1'b1) begin errors++; $display("FAIL eto_flag: got %b expected 1", dv_tout[0][0]); end
            checks++; if (dv_cyc[0] - rise_cyc !== ECHO + 2) begin errors++; $display("FAIL eto_time: got %0d expected %0d", dv_cyc[0] - rise_cyc, ECHO + 2); end
        end
        clear_log();
        echo_w = '{2700, 0, 0, 0};
        enable = 4'b0001;
        wait_dv(1, 4000, ok);
        enable = 4'b0000;
        wait_idle(4000, ok2);
        checks++; if (ok !== 1'b1 || ok2 !== 1'b1) begin errors++; $display("FAIL sat_progress: got %b%b expected 11", ok, ok2); end
        if (ok) begin
            checks++; if (dv_dist[0][7:0] !== 8'd255) begin errors++; $display("FAIL sat_byte: got %0d expected 255", dv_dist[0][7:0]); end
            checks++; if (dv_tout[0][0] !== 1'b0) begin errors++; $display("FAIL sat_flag: got %b expected 0", dv_tout[0][0]); end
        end
    endtask

    task automatic test_abort_and_disable();
        bit ok, ok2, up;
        pulse_reset();
        clear_log();
        echo_w = '{0, 500, 0, 0};
        enable = 4'b0010;
        up = 1'b0;
        for (int i = 0; i < 500 && !up; i++) begin
            @(negedge clk);
            up = sig_in[1];
        end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        enable = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (up !== 1'b1) begin errors++; $display("FAIL abort_echo_seen: got %b expected 1", up); end
        checks++; if (sig_oe !== 4'b0000) begin errors++; $display("FAIL abort_oe: got %b expected 0000", sig_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (distance !== 32'h0) begin errors++; $display("FAIL abort_dist: got %h expected 0", distance); end
        wait_idle(1000, ok);
        checks++; if (dv_mask.size() !== 0) begin errors++; $display("FAIL abort_no_result: got %0d expected 0", dv_mask.size()); end
        clear_log();
        enable = 4'b0010;
        up = 1'b0;
        for (int i = 0; i < 500 && !up; i++) begin
            @(negedge clk);
            up = sig_in[1];
        end
        repeat (100) @(negedge clk);
        enable = 4'b0000;
        wait_dv(1, 2000, ok);
        wait_idle(2000, ok2);
        checks++; if (ok !== 1'b1 || ok2 !== 1'b1) begin errors++; $display("FAIL dis_progress: got %b%b expected 11", ok, ok2); end
        if (ok) begin
            checks++; if (dv_mask[0] !== 4'b0010) begin errors++; $display("FAIL dis_valid: got %b expected 0010", dv_mask[0]); end
            checks++; if (dv_dist[0][15:8] !== 8'd50) begin errors++; $display("FAIL dis_byte: got %0d expected 50", dv_dist[0][15:8]); end
            checks++; if (dv_tout[0][1] !== 1'b0) begin errors++; $display("FAIL dis_flag: got %b expected 0", dv_tout[0][1]); end
            checks++; if (dv_idx[0] !== 2'd1) begin errors++; $display("FAIL dis_idx: got %0d expected 1", dv_idx[0]); end
        end
    endtask

    initial begin
        for (int b = 0; b < 4; b++) echo_w[b] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_rise_timeout();
        test_long_echo();
        test_abort_and_disable();
        checks++; if (viol !== 0) begin errors++; $display("FAIL pin_invariants: got %0d expected 0", viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
